// File: rtl/visit_lookup_if.sv
// Request/response bundle for visit_lookup. The unique_count signal exists only
// when VISIT_LOOKUP_COUNT_EN is defined.
interface visit_lookup_if #(
    parameter int unsigned POSITION_WIDTH = 8
);
    logic                      pos_change;
    logic [POSITION_WIDTH-1:0] pos_x;
    logic [POSITION_WIDTH-1:0] pos_y;
    logic                      ready;
    logic                      lookup_valid;
    logic                      lookup_already_visited;
    logic                      drop_error;
`ifdef VISIT_LOOKUP_COUNT_EN
    logic [15:0]               unique_count;

    modport master (
        output pos_change, pos_x, pos_y,
        input  ready, lookup_valid, lookup_already_visited, drop_error, unique_count
    );
    modport slave (
        input  pos_change, pos_x, pos_y,
        output ready, lookup_valid, lookup_already_visited, drop_error, unique_count
    );
`else
    modport master (
        output pos_change, pos_x, pos_y,
        input  ready, lookup_valid, lookup_already_visited, drop_error
    );
    modport slave (
        input  pos_change, pos_x, pos_y,
        output ready, lookup_valid, lookup_already_visited, drop_error
    );
`endif
endinterface

// File: rtl/visit_lookup.sv
// Visited-position bitmap: clears a 1-bit-per-(x,y) RAM, then answers "seen before?"
// with 2-cycle latency. Optional macro VISIT_LOOKUP_COUNT_EN adds a unique-visit counter.
module visit_lookup #(
    parameter int unsigned POSITION_WIDTH = 8,
    parameter int unsigned WORD_WIDTH     = 32
) (
    input  logic            clk,
    input  logic            reset,
    visit_lookup_if.slave   lookup_if
);
    localparam int unsigned BIT_W  = $clog2(WORD_WIDTH);
    localparam int unsigned ADDR_W = 2 * POSITION_WIDTH - BIT_W;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic                clr_we;
    logic                ready_q, ready_d;
    logic                drop_q;

    logic                accept;
    logic [ADDR_W-1:0]   req_addr;
    logic [BIT_W-1:0]    req_bit;

    logic                s1_valid_q;
    logic [ADDR_W-1:0]   s1_addr_q;
    logic [BIT_W-1:0]    s1_bit_q;
    logic                s2_valid_q;
    logic                s2_hit_q;
    logic [ADDR_W-1:0]   s2_addr_q;
    logic [WORD_WIDTH-1:0] s2_word_q;
    logic                lookup_valid_q;
    logic                lookup_hit_q;

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [WORD_WIDTH-1:0] rd_data_q;
    logic [WORD_WIDTH-1:0] merged;
    logic [WORD_WIDTH-1:0] new_word;
    logic                  hit;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_waddr;
    logic [WORD_WIDTH-1:0] mem_wdata;

    // Word address is {y, x upper bits}; the low x bits select the bit in the word.
    assign req_addr = ADDR_W'({lookup_if.pos_y, lookup_if.pos_x} >> BIT_W);
    assign req_bit  = lookup_if.pos_x[BIT_W-1:0];
    assign accept   = lookup_if.pos_change && (state_q == ST_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_CLEAR;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_addr_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        ready_d    = (state_d == ST_RUN);
        clr_we     = 1'b0;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR) begin
            clr_we     = 1'b1;
            clr_addr_d = ADDR_W'(clr_addr_q + 1'b1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            clr_addr_q <= clr_addr_d;
            ready_q    <= ready_d;
            drop_q     <= drop_q | (lookup_if.pos_change && (state_q != ST_RUN));
        end
    end

    // Forward last cycle's write-back when it hit the same word (RAM read is read-first).
    assign merged   = (s2_valid_q && (s2_addr_q == s1_addr_q)) ? s2_word_q : rd_data_q;
    assign hit      = merged[s1_bit_q];
    assign new_word = merged | (WORD_WIDTH'(1) << s1_bit_q);

    assign mem_we    = clr_we | s1_valid_q;
    assign mem_waddr = clr_we ? clr_addr_q : s1_addr_q;
    assign mem_wdata = clr_we ? '0 : new_word;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (accept) rd_data_q <= mem[req_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q     <= 1'b0;
            s1_addr_q      <= '0;
            s1_bit_q       <= '0;
            s2_valid_q     <= 1'b0;
            s2_hit_q       <= 1'b0;
            s2_addr_q      <= '0;
            s2_word_q      <= '0;
            lookup_valid_q <= 1'b0;
            lookup_hit_q   <= 1'b0;
        end else begin
            s1_valid_q     <= accept;
            s1_addr_q      <= req_addr;
            s1_bit_q       <= req_bit;
            s2_valid_q     <= s1_valid_q;
            s2_addr_q      <= s1_addr_q;
            if (s1_valid_q) begin
                s2_hit_q  <= hit;
                s2_word_q <= new_word;
            end
            lookup_valid_q <= s2_valid_q;
            lookup_hit_q   <= s2_hit_q;
        end
    end

    assign lookup_if.ready                  = ready_q;
    assign lookup_if.lookup_valid           = lookup_valid_q;
    assign lookup_if.lookup_already_visited = lookup_hit_q;
    assign lookup_if.drop_error             = drop_q;

`ifdef VISIT_LOOKUP_COUNT_EN
    logic [15:0] unique_count_q;

    // Saturating count of first visits, following the registered result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            unique_count_q <= '0;
        end else if (lookup_valid_q && !lookup_hit_q && (unique_count_q != 16'hFFFF)) begin
            unique_count_q <= unique_count_q + 16'd1;
        end
    end

    assign lookup_if.unique_count = unique_count_q;
`endif

endmodule

// File: doc/visit_lookup.md
VISIT_LOOKUP -- requirements
Module: visit_lookup

Interface
REQ-001 Parameter POSITION_WIDTH, default 8, is the width of each coordinate (x, y).
REQ-002 Parameter WORD_WIDTH, default 32, is the bitmap RAM word width; a power of 2, at most 2**POSITION_WIDTH.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pos_change  input  1  one-cycle strobe: pos_x/pos_y hold a newly reached position.
REQ-006 pos_x  input  POSITION_WIDTH  x coordinate, unsigned.
REQ-007 pos_y  input  POSITION_WIDTH  y coordinate, unsigned.
REQ-008 ready  output  1  high when the bitmap clear is complete and requests are accepted.
REQ-009 lookup_valid  output  1  one-cycle strobe: lookup result available.
REQ-010 lookup_already_visited  output  1  1 = position was marked before this request, 0 = first visit; valid only with lookup_valid.
REQ-011 drop_error  output  1  sticky flag: a pos_change arrived while ready was low.

Function
REQ-012 Bitmap: 2**(2*POSITION_WIDTH) bits, one per (x,y), held as DEPTH = 2**(2*POSITION_WIDTH)/WORD_WIDTH words.
REQ-013 Word address = {pos_y, pos_x[POSITION_WIDTH-1:log2(WORD_WIDTH)]}; bit index = pos_x[log2(WORD_WIDTH)-1:0].
REQ-014 RAM: single-clock, synchronous read (1-cycle latency), read-first on a same-address read/write; infers block RAM (no reset on the array).
REQ-015 FSM states CLEAR and RUN; reset enters CLEAR with clear address 0.
REQ-016 CLEAR: one zero word written per cycle, address ascending 0..DEPTH-1; after writing DEPTH-1, go to RUN on the next edge; ready = 1 only in RUN.
REQ-017 RUN: pos_change sampled high at edge N issues a read of the word at edge N.
REQ-018 At edge N+1, the word is merged and the bit is tested: hit = merged[bit].
REQ-019 At edge N+1, merged | (1 << bit) is written back to the same word.
REQ-020 At edge N+2, lookup_valid = 1 and lookup_already_visited = hit; fixed latency is 2 cycles.
REQ-021 Throughput: one request per cycle, back-to-back accepted.
REQ-022 Hazard: if the previous cycle wrote the same word, merged = the forwarded write data, not the RAM read data; same position twice in a row returns 0 then 1.
REQ-023 pos_change while ready = 0 is ignored (no RAM access, no lookup_valid) and sets drop_error.
REQ-024 Coordinates wrap naturally; there is no range error inside this block.

Reset
REQ-025 Reset values: ready = 0, lookup_valid = 0, lookup_already_visited = 0, drop_error = 0, pipeline valids = 0, FSM = CLEAR, clear address = 0.
REQ-026 Reset asserted mid-operation aborts in-flight requests (no lookup_valid emitted) and restarts the full CLEAR sweep.

Configuration
REQ-027 With macro VISIT_LOOKUP_COUNT_EN defined, output unique_count [15:0] is added.
REQ-028 unique_count resets to 0, increments on each lookup_valid with lookup_already_visited = 0, and saturates at 16'hFFFF.
REQ-029 Without VISIT_LOOKUP_COUNT_EN, the port and counter are absent; all other behaviour is identical.

Verification
REQ-030 Reset release, defaults -> ready rises exactly DEPTH cycles later (2048 for 8/32); lookup_valid stays 0 throughout.
REQ-031 In RUN, pos_change at (0x80,0x80) then (0x81,0x80) then (0x80,0x80), with gaps -> already_visited results 0, 0, 1, each 2 cycles after its strobe.
REQ-032 Back-to-back strobes on (0x10,0x20), (0x10,0x20), (0x11,0x20) -> results 0, 1, 0 on consecutive cycles (forwarding path).
REQ-033 pos_change at cycle 5 after reset (ready = 0) -> no lookup_valid and drop_error = 1 until the next reset.
REQ-034 Mark (0xFF,0xFF), assert reset mid-pipeline, re-clear, query (0xFF,0xFF) -> result 0; with VISIT_LOOKUP_COUNT_EN, unique_count = 1.
REQ-035 Random stream of 10000 positions checked against a software set model -> every result and the final unique_count match.
